// File: rtl/design_sel_sequencer.sv
// Design-select sequencer: holds the shared reset override low, swaps design_sel while the
// designs sit in reset, lets them settle, then releases. Optional auto-demo rotation.
module design_sel_sequencer #(
  parameter int unsigned RST_HOLD = 16,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned MAX_SEL  = 6,
  parameter int unsigned DWELL_W  = 24
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [2:0]         req_sel,
  output logic               req_ready,
  input  logic               auto_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         design_sel,
  output logic               rst_override_n,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned CntMax = (RST_HOLD > SETTLE) ? RST_HOLD : SETTLE;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [2:0]         MaxSel   = 3'(MAX_SEL);
  localparam logic [CntW-1:0]    CntOne   = CntW'(1);
  localparam logic [CntW-1:0]    HoldLd   = CntW'(RST_HOLD - 1);
  localparam logic [CntW-1:0]    SettleLd = CntW'(SETTLE - 1);
  localparam logic [DWELL_W-1:0] DwellOne = DWELL_W'(1);

  typedef enum logic [1:0] {StIdle, StDrain, StSettle} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         target_q, target_d;
  logic [2:0]         sel_q, sel_d;
  logic               ovr_n_q, ovr_n_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

  logic       accept;
  logic       auto_on;
  logic       auto_fire;
  logic [2:0] auto_target;

  assign req_ready = (state_q == StIdle) && rst_n;
  assign busy      = (state_q != StIdle) && rst_n;
  assign accept    = req_valid && req_ready;
  assign auto_on   = auto_en && (dwell != '0);
  // >= rather than == so that shrinking dwell mid-count fires on the next idle edge.
  assign auto_fire = auto_on && (state_q == StIdle) && (dwell_cnt_q >= dwell - DwellOne);
  assign auto_target = ((sel_q >= MaxSel) || (sel_q == 3'd0)) ? 3'd1 : sel_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    sel_d       = sel_q;
    ovr_n_d     = ovr_n_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    dwell_cnt_d = dwell_cnt_q;

    unique case (state_q)
      StIdle: begin
        ovr_n_d = 1'b1;
        // Host request has priority over the auto trigger, even when it is invalid.
        if (accept) begin
          dwell_cnt_d = '0;
          if (req_sel > MaxSel) begin
            err_d = 1'b1;
          end else begin
            target_d = req_sel;
            ovr_n_d  = 1'b0;
            cnt_d    = HoldLd;
            state_d  = StDrain;
          end
        end else if (auto_fire) begin
          dwell_cnt_d = '0;
          target_d    = auto_target;
          ovr_n_d     = 1'b0;
          cnt_d       = HoldLd;
          state_d     = StDrain;
        end else if (auto_on) begin
          dwell_cnt_d = dwell_cnt_q + DwellOne;
        end
      end
      StDrain: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == '0) begin
          sel_d   = target_q;
          cnt_d   = SettleLd;
          state_d = StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == '0) begin
          ovr_n_d     = 1'b1;
          done_d      = 1'b1;
          dwell_cnt_d = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!auto_on) dwell_cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      target_q    <= '0;
      sel_q       <= '0;
      ovr_n_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      sel_q       <= sel_d;
      ovr_n_q     <= ovr_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign design_sel     = sel_q;
  assign rst_override_n = ovr_n_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
